uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_fifo.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states and oversampling ratio.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through byte FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [7:0]             wdata_i,
    output logic [7:0]             rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pop, wr;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];
    assign pop     = pop_i && !empty_o;
    assign wr      = push_i && (!full_o || pop);
    assign cnt_d   = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(pop);
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver feeding a byte FIFO with
// sticky frame-error and overrun flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic                   Rx,
    input  logic                   Rx_en,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [7:0]             data_out,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    logic [DW-1:0] div_q;
    logic          tick, s1_q, s2_q, rx_s;
    state_e        state_q, state_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          ferr_q, ferr_d, ovr_q, ovr_d, wr_req, ferr_set;
    assign tick = div_q == DW'(DIV - 1);
    assign rx_s = s2_q;
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tick ? tcnt_q + 4'd1 : tcnt_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        wr_req   = 1'b0;
        ferr_set = 1'b0;
        if (!Rx_en) state_d = IDLE;
        else case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                tcnt_d  = '0;
            end
            START: if (tick && tcnt_q == 4'(OVERSAMPLE / 2 - 1)) begin
                state_d = rx_s ? IDLE : DATA;
                tcnt_d  = '0;
                bcnt_d  = '0;
            end
            DATA: if (tick && tcnt_q == 4'(OVERSAMPLE - 1)) begin
                sh_d    = {rx_s, sh_q[7:1]};
                bcnt_d  = bcnt_q + 3'd1;
                state_d = bcnt_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick && tcnt_q == 4'(OVERSAMPLE - 1)) begin
                state_d  = IDLE;
                wr_req   = rx_s;
                ferr_set = !rx_s;
            end
            default: state_d = IDLE;
        endcase
        ferr_d = ferr_set || (ferr_q && !err_clr);
        ovr_d  = (wr_req && full && !rd_en) || (ovr_q && !err_clr);
    end
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            div_q   <= tick ? '0 : div_q + DW'(1);
            s1_q    <= Rx;
            s2_q    <= s1_q;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_50m),
        .rst_i   (rst),
        .push_i  (wr_req),
        .pop_i   (rd_en),
        .wdata_i (sh_q),
        .rdata_o (data_out),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frame scenarios against uart_rx_fifo at 432 clocks per bit.
module tb_uart_rx_fifo;
    import uart_pkg::*;
    localparam int BIT = 432;
    logic       clk_50m = 1'b0;
    logic       rst, Rx = 1'b1, Rx_en = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] data_out;
    logic       empty, full, frame_err, overrun;
    logic [3:0] count;
    int         total = 0, bad = 0;

    always #5 clk_50m = ~clk_50m;

    uart_rx_fifo dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .Rx        (Rx),
        .Rx_en     (Rx_en),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_hi, input int stop_len);
        Rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            cyc(BIT);
        end
        Rx = stop_hi;
        cyc(stop_len);
        Rx = 1'b1;
        cyc(stop_hi ? 40 : BIT);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        cyc(3);
        total++;
        if ({empty, full, count, frame_err, overrun} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got e=%b f=%b c=%0d fe=%b ov=%b want e=1 f=0 c=0 fe=0 ov=0",
                     empty, full, count, frame_err, overrun);
        end
        rst = 1'b0;
        cyc(5);
        total++;
        if (dut.state_q !== IDLE || empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got state=%0d empty=%b want state=0 empty=1", dut.state_q, empty);
        end
    endtask

    task automatic test_single();
        send_byte(8'hA5, 1'b1, BIT);
        total++;
        if (data_out !== 8'hA5 || count !== 4'd1 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL single_a5 got data=%h count=%0d fe=%b want data=a5 count=1 fe=0",
                     data_out, count, frame_err);
        end
    endtask

    task automatic test_mid_reset();
        fork
            send_byte(8'hFF, 1'b1, BIT);
            begin
                cyc(5 * BIT + 200);
                rst = 1'b1;
                cyc(3);
                total++;
                if (count !== 4'd0 || empty !== 1'b1 || dut.state_q !== IDLE) begin
                    bad++;
                    $display("FAIL mid_reset_clear got count=%0d empty=%b state=%0d want 0 1 0",
                             count, empty, dut.state_q);
                end
                rst = 1'b0;
            end
        join
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset_tail got count=%0d want 0", count);
        end
        send_byte(8'h5A, 1'b1, BIT);
        total++;
        if (count !== 4'd1 || data_out !== 8'h5A) begin
            bad++;
            $display("FAIL mid_reset_5a got count=%0d data=%h want count=1 data=5a", count, data_out);
        end
        pop();
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pop got empty=%b want 1", empty);
        end
    endtask

    task automatic test_false_start();
        Rx = 1'b0;
        cyc(50);
        total++;
        if (dut.state_q !== START) begin
            bad++;
            $display("FAIL false_start_enter got state=%0d want %0d", dut.state_q, START);
        end
        cyc(50);
        Rx = 1'b1;
        cyc(400);
        total++;
        if (dut.state_q !== IDLE || count !== 4'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL false_start got state=%0d count=%0d fe=%b ov=%b want 0 0 0 0",
                     dut.state_q, count, frame_err, overrun);
        end
    endtask

    task automatic test_frame_err();
        send_byte(8'h3C, 1'b0, 260);
        total++;
        if (frame_err !== 1'b1 || count !== 4'd0) begin
            bad++;
            $display("FAIL frame_err_set got fe=%b count=%0d want fe=1 count=0", frame_err, count);
        end
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL frame_err_clr got fe=%b want 0", frame_err);
        end
    endtask

    task automatic test_fill_overrun();
        for (int b = 1; b <= 9; b++) begin
            send_byte(8'(b), 1'b1, BIT);
            if (b == 7) begin
                total++;
                if (full !== 1'b0 || count !== 4'd7) begin
                    bad++;
                    $display("FAIL fill_7 got full=%b count=%0d want full=0 count=7", full, count);
                end
            end
            if (b == 8) begin
                total++;
                if (full !== 1'b1 || count !== 4'd8 || overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_8 got full=%b count=%0d ov=%b want 1 8 0", full, count, overrun);
                end
            end
        end
        total++;
        if (overrun !== 1'b1 || count !== 4'd8 || data_out !== 8'h01) begin
            bad++;
            $display("FAIL overrun_9 got ov=%b count=%0d head=%h want 1 8 01", overrun, count, data_out);
        end
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clr got ov=%b want 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] popped;
        logic [7:0] exp [8];
        exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h77};
        popped = 8'h00;
        fork
            send_byte(8'h77, 1'b1, BIT);
            begin
                int n;
                n = 0;
                while (dut.wr_req !== 1'b1 && n < 6000) begin
                    cyc(1);
                    n++;
                end
                total++;
                if (dut.wr_req !== 1'b1) begin
                    bad++;
                    $display("FAIL push_pop_timeout got no write within %0d cycles want write", n);
                end else begin
                    popped = data_out;
                    rd_en = 1'b1;
                    cyc(1);
                    rd_en = 1'b0;
                end
            end
        join
        total++;
        if (popped !== 8'h01 || count !== 4'd8 || full !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL push_pop_full got popped=%h count=%0d full=%b ov=%b want 01 8 1 0",
                     popped, count, full, overrun);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (data_out !== exp[i] || empty !== 1'b0) begin
                bad++;
                $display("FAIL drain_%0d got data=%h empty=%b want data=%h empty=0", i, data_out, empty, exp[i]);
            end
            pop();
        end
        total++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            bad++;
            $display("FAIL drain_empty got empty=%b count=%0d want 1 0", empty, count);
        end
        pop();
        total++;
        if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin
            bad++;
            $display("FAIL pop_empty got empty=%b count=%0d full=%b want 1 0 0", empty, count, full);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mid_reset();
        test_false_start();
        test_frame_err();
        test_fill_overrun();
        test_full_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
